// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
//   Self-test controller for a small N-input combinational gate. Each start
//   pulse walks the gate through every input vector in ascending order. Each
//   vector is held for SETTLE cycles. The gate output is then compared against
//   the expected reduction function in a single CHECK cycle. Mismatches are
//   counted with saturation. The first failing vector is latched. A one-cycle
//   done pulse ends the run and reports pass/fail.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin a run (sampled only in IDLE)
//   op         expected function: 00 AND, 01 OR, 10 XOR, 11 NAND (latched at start)
//   dut_in     vector driven to the gate inputs (bit 0 = first input)
//   dut_y      gate output (sampled only in CHECK)
//   busy       high while a run is in progress
//   done       one-cycle pulse at end of run
//   pass       run finished with zero errors; held until next start
//   err_count  mismatches in current/last run, saturating
//   fail_valid a mismatch has been recorded in current/last run
//   fail_vec   first mismatching vector; valid when fail_valid=1
//
// States
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_WAIT  | holding dut_in for SETTLE cycles
//   ST_CHECK | sampling dut_y and comparing with the expected value
//   ST_DONE  | one-cycle done pulse; pass is valid

module gate_test_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail_valid,
  output logic [N_IN-1:0]   fail_vec
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  // Vector counter carries one extra bit so the last-vector compare cannot wrap.
  localparam logic [N_IN:0]    LAST_VEC = {1'b0, {N_IN{1'b1}}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [N_IN:0]    vec;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             expected;
  logic             mismatch;
  logic             last_vec;

  logic load_run;
  logic cnt_inc;
  logic do_check;
  logic adv_vec;

  assign dut_in   = vec[N_IN-1:0];
  assign last_vec = (vec == LAST_VEC);

  always_comb begin
    expected = 1'b0;
    case (op_q)
      2'b00:   expected = &dut_in;
      2'b01:   expected = |dut_in;
      2'b10:   expected = ^dut_in;
      default: expected = ~&dut_in;
    endcase
  end

  assign mismatch = (dut_y != expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load_run  = 1'b0;
    cnt_inc   = 1'b0;
    do_check  = 1'b0;
    adv_vec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_run  = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = ST_CHECK;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_CHECK: begin
        busy     = 1'b1;
        do_check = 1'b1;
        if (last_vec) begin
          state_nxt = ST_DONE;
        end else begin
          adv_vec   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= '0;
      cnt        <= '0;
      op_q       <= 2'b00;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      pass       <= 1'b0;
    end else begin
      if (load_run) begin
        op_q       <= op;
        vec        <= '0;
        cnt        <= '0;
        err_count  <= '0;
        fail_valid <= 1'b0;
        fail_vec   <= '0;
        pass       <= 1'b0;
      end
      if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (do_check) begin
        if (mismatch) begin
          if (err_count != ERR_MAX) begin
            err_count <= err_count + ERR_W'(1);
          end
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= dut_in;
          end
        end
        // pass is resolved here so it already reflects the final compare
        // when DONE is presented.
        if (last_vec) begin
          pass <= !mismatch && (err_count == '0);
        end
        if (adv_vec) begin
          vec <= vec + (N_IN + 1)'(1);
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
module tb_gate_test_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  int         n_checks = 0;
  int         n_errors = 0;

  // DUT A: default parameters (2 inputs, settle 2, 8-bit error counter)
  logic       start_a;
  logic [1:0] op_a;
  logic [1:0] dut_in_a;
  logic       dut_y_a;
  logic       busy_a, done_a, pass_a, fail_valid_a;
  logic [7:0] err_count_a;
  logic [1:0] fail_vec_a;
  logic [1:0] gate_mode;  // 0 AND gate, 1 XOR gate, 2 stuck-at-1

  // DUT B: 3 inputs, 2-bit error counter, gate always wrong for op AND
  logic       start_b;
  logic [1:0] op_b;
  logic [2:0] dut_in_b;
  logic       dut_y_b;
  logic       busy_b, done_b, pass_b, fail_valid_b;
  logic [1:0] err_count_b;
  logic [2:0] fail_vec_b;

  always #5 clk = ~clk;

  always_comb begin
    case (gate_mode)
      2'd0:    dut_y_a = &dut_in_a;
      2'd1:    dut_y_a = ^dut_in_a;
      default: dut_y_a = 1'b1;
    endcase
  end

  assign dut_y_b = ~(&dut_in_b);

  gate_test_sequencer u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start_a),
    .op         (op_a),
    .dut_in     (dut_in_a),
    .dut_y      (dut_y_a),
    .busy       (busy_a),
    .done       (done_a),
    .pass       (pass_a),
    .err_count  (err_count_a),
    .fail_valid (fail_valid_a),
    .fail_vec   (fail_vec_a)
  );

  gate_test_sequencer #(.N_IN(3), .SETTLE(2), .ERR_W(2)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .op         (op_b),
    .dut_in     (dut_in_b),
    .dut_y      (dut_y_b),
    .busy       (busy_b),
    .done       (done_b),
    .pass       (pass_b),
    .err_count  (err_count_b),
    .fail_valid (fail_valid_b),
    .fail_vec   (fail_vec_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on DUT A and scan forward one cycle per negedge until done.
  // done_cyc is the cycle offset from the start edge (-1 on timeout).
  task automatic run_a(input logic [1:0] op_v, input bit seq_chk, output int done_cyc);
    @(negedge clk);
    op_a    = op_v;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a  = 1'b0;
    op_a     = ~op_v;  // must not affect the run in progress
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) begin
        check("start_busy", 32'(busy_a), 32'd1);
        check("start_err_clr", 32'(err_count_a), 32'd0);
        check("start_fv_clr", 32'(fail_valid_a), 32'd0);
        check("start_pass_clr", 32'(pass_a), 32'd0);
      end
      if (seq_chk && c <= 12) check("dut_in_seq", 32'(dut_in_a), 32'((c - 1) / 3));
      if (done_a) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int dc;
    int n_done;
    int first_done;
    int second_done;

    rst       = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    op_a      = 2'b00;
    op_b      = 2'b00;
    gate_mode = 2'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_done", 32'(done_a), 32'd0);
      check("idle_dut_in", 32'(dut_in_a), 32'd0);
      check("idle_err", 32'(err_count_a), 32'd0);
      check("idle_pass", 32'(pass_a), 32'd0);
      check("idle_busy_b", 32'(busy_b), 32'd0);
      @(negedge clk);
    end

    // Correct AND gate
    gate_mode = 2'd0;
    run_a(2'b00, 1'b1, dc);
    check("and_done_cyc", 32'(dc), 32'd13);
    check("and_pass", 32'(pass_a), 32'd1);
    check("and_err", 32'(err_count_a), 32'd0);
    check("and_fv", 32'(fail_valid_a), 32'd0);
    check("and_busy_in_done", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("and_done_one_cycle", 32'(done_a), 32'd0);
    check("and_pass_held", 32'(pass_a), 32'd1);

    // Stuck-at-1 gate against AND: vectors 00, 01, 10 mismatch
    gate_mode = 2'd2;
    run_a(2'b00, 1'b0, dc);
    check("stuck_done_cyc", 32'(dc), 32'd13);
    check("stuck_err", 32'(err_count_a), 32'd3);
    check("stuck_fv", 32'(fail_valid_a), 32'd1);
    check("stuck_fvec", 32'(fail_vec_a), 32'd0);
    check("stuck_pass", 32'(pass_a), 32'd0);

    // Correct XOR gate
    gate_mode = 2'd1;
    run_a(2'b10, 1'b0, dc);
    check("xor_done_cyc", 32'(dc), 32'd13);
    check("xor_pass", 32'(pass_a), 32'd1);
    check("xor_err", 32'(err_count_a), 32'd0);

    // NAND expectation against XOR gate: XOR=0,1,1,0 vs NAND=1,1,1,0,
    // so only vector 00 differs.
    run_a(2'b11, 1'b0, dc);
    check("nand_done_cyc", 32'(dc), 32'd13);
    check("nand_err", 32'(err_count_a), 32'd1);
    check("nand_fv", 32'(fail_valid_a), 32'd1);
    check("nand_fvec", 32'(fail_vec_a), 32'd0);
    check("nand_pass", 32'(pass_a), 32'd0);

    // Reset during vector 10 settle
    gate_mode = 2'd2;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_vec", 32'(dut_in_a), 32'd2);
    check("mid_err", 32'(err_count_a), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_dut_in", 32'(dut_in_a), 32'd0);
    check("rst_err", 32'(err_count_a), 32'd0);
    check("rst_fv", 32'(fail_valid_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a) n_done++;
    end
    check("rst_no_done", 32'(n_done), 32'd0);

    // start held high: second run starts on the first IDLE cycle after DONE
    gate_mode = 2'd0;
    op_a = 2'b00;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    n_done = 0;
    first_done = -1;
    second_done = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 20) start_a = 1'b0;
      if (done_a) begin
        n_done++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
    end
    check("held_n_done", 32'(n_done), 32'd2);
    check("held_first", 32'(first_done), 32'd13);
    check("held_second", 32'(second_done), 32'd27);

    // Saturation and start-ignore on DUT B
    @(negedge clk);
    op_b = 2'b00;
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    n_done = 0;
    first_done = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) start_b = 1'b1;
      if (c == 11) start_b = 1'b0;
      if (done_b) begin
        n_done++;
        if (first_done < 0) begin
          first_done = c;
          check("sat_err", 32'(err_count_b), 32'd3);
          check("sat_fv", 32'(fail_valid_b), 32'd1);
          check("sat_fvec", 32'(fail_vec_b), 32'd0);
          check("sat_pass", 32'(pass_b), 32'd0);
        end
      end
      @(negedge clk);
    end
    check("sat_done_cyc", 32'(first_done), 32'd25);
    check("sat_n_done", 32'(n_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
